adder_share_arbiter: RTL and testbench

- Time-shares one 4-bit two's-complement ripple adder (`signed_adder_4bit`) between N_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Each requester issues A+B through a req/gnt handshake and receives the sum and overflow flag on a shared, tagged response channel with backpressure.
- Sits between the small ALU clients and the shared adder datapath.

---
 rtl/adder_share_pkg.sv | 13 +
 rtl/signed_adder_4bit.sv | 28 ++
 rtl/adder_share_arbiter.sv | 127 ++++++++++++
 tb/tb_adder_share_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and clamp limits for the time-shared 4-bit adder arbiter.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic signed [3:0] SAT_MAX = 4'sd7;
    localparam logic signed [3:0] SAT_MIN = -4'sd8;

endpackage

// File: rtl/signed_adder_4bit.sv
// 4-bit two's-complement ripple adder exposing carry into and out of the sign bit.
// Latency: purely combinational.
// Backpressure: none, the caller holds operands as long as it needs the result.
module signed_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c3,
    output logic       cout
);

    always_comb begin : ripple
        logic carry;
        carry = cin;
        sum   = '0;
        c3    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                c3 = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one signed 4-bit adder among N_REQ requesters, one op in flight.
// Latency: grant edge -> rsp_valid one cycle later; one op per 3 cycles at full rate.
// Backpressure: rsp_ready low parks the FSM in RESP with the response held; no grants meanwhile.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] a_in,
    input  logic [4*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [3:0]         rsp_sum,
    output logic               rsp_ovf
);

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] op_id;
    logic [ID_W-1:0] win;
    logic [3:0]      op_a;
    logic [3:0]      op_b;
    logic [3:0]      sel_a;
    logic [3:0]      sel_b;
    logic [3:0]      add_sum;
    logic [3:0]      res_sum;
    logic            add_c3;
    logic            add_cout;
    logic            add_ovf;

    // Lowest requester at or above ptr wins; otherwise the lowest one overall (wrap).
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] w;
        w = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                w = ID_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i] && (i >= int'(ptr))) begin
                w = ID_W'(i);
            end
        end
        return w;
    endfunction

    always_comb begin
        win   = rr_pick(req, rr_ptr);
        gnt   = '0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_a = a_in[4*i +: 4];
                sel_b = b_in[4*i +: 4];
                if (rst_n && (state == IDLE) && (|req)) begin
                    gnt[i] = 1'b1;
                end
            end
        end
    end

    signed_adder_4bit u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .c3   (add_c3),
        .cout (add_cout)
    );

    assign add_ovf = add_c3 ^ add_cout;
    // Overflow only happens with equal operand signs, so A's sign picks the rail.
    assign res_sum = ((SATURATE != 0) && add_ovf) ? (op_a[3] ? SAT_MIN : SAT_MAX) : add_sum;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_id  <= win;
                        rr_ptr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= res_sum;
                    rsp_ovf   <= add_ovf;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench: a wrapping and a saturating instance share the same stimulus.
module tb_adder_share_arbiter;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] sum;
        logic       ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] a_in, b_in;
    logic        rsp_ready;
    logic [3:0]  gnt0, gnt1, rsum0, rsum1;
    logic [1:0]  rid0, rid1;
    logic        busy0, busy1, rv0, rv1, rovf0, rovf1;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   glog_id[$];
    int   glog_cyc[$];
    int   m_ptr = 0;
    bit   m_out = 0;
    int   since = 99;
    bit   hold[2];
    logic [1:0] hid[2], last_id[2];
    logic [3:0] hsum[2], last_sum[2];
    logic       hovf[2], last_ovf[2];
    int   n_rsp[2];

    adder_share_arbiter #(.N_REQ(4), .ID_W(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt0),
        .busy(busy0), .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_id(rid0),
        .rsp_sum(rsum0), .rsp_ovf(rovf0));

    adder_share_arbiter #(.N_REQ(4), .ID_W(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt1),
        .busy(busy1), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(rid1),
        .rsp_sum(rsum1), .rsp_ovf(rovf1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: cyclic search from the pointer; sums done in plain integer arithmetic.
    function automatic int rr_ref(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void ref_add(input bit sat, input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] s, output logic o);
        int t;
        t = $signed(a) + $signed(b);
        o = (t > 7) || (t < -8);
        if (o && sat) s = (t > 7) ? 4'd7 : 4'd8;
        else          s = 4'(t);
    endfunction

    // Grant-side model: predicts each grant and pushes the expected response.
    always @(negedge clk) begin : grant_model
        int w;
        logic [3:0] eg, s;
        logic o;
        if (!rst_n) begin
            m_ptr = 0;
            m_out = 0;
            since = 99;
            q0.delete();
            q1.delete();
        end else begin
            chk("busy0", busy0, m_out);
            chk("busy1", busy1, m_out);
            w  = rr_ref(req, m_ptr);
            eg = (!m_out && w >= 0) ? 4'(1 << w) : 4'b0;
            chk("gnt0", gnt0, eg);
            chk("gnt1", gnt1, eg);
            if (eg != 4'b0) begin
                ref_add(1'b0, a_in[4*w +: 4], b_in[4*w +: 4], s, o);
                q0.push_back('{2'(w), s, o});
                ref_add(1'b1, a_in[4*w +: 4], b_in[4*w +: 4], s, o);
                q1.push_back('{2'(w), s, o});
                m_ptr = (w + 1) % N;
                m_out = 1;
                since = 0;
                glog_id.push_back(w);
                glog_cyc.push_back(cyc);
            end else if (since < 99) begin
                since++;
            end
            if (since == 1) chk("exec_no_vld", rv0, 1'b0);
            if (since == 2) chk("rsp_latency", rv0, 1'b1);
            if (m_out && rv0 && rsp_ready) m_out = 0;
        end
    end

    task automatic mon_one(input int d, input logic v, input logic [1:0] id,
                           input logic [3:0] s, input logic o);
        exp_t e;
        if (hold[d]) begin
            chk($sformatf("hold_vld%0d", d), v, 1'b1);
            chk($sformatf("hold_id%0d", d), id, hid[d]);
            chk($sformatf("hold_sum%0d", d), s, hsum[d]);
            chk($sformatf("hold_ovf%0d", d), o, hovf[d]);
        end
        if (v && rsp_ready) begin
            hold[d] = 0;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                checks++;
                fails++;
                $display("FAIL rsp_unexpected%0d: got a response, expected none", d);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("rsp_id%0d", d), id, e.id);
                chk($sformatf("rsp_sum%0d", d), s, e.sum);
                chk($sformatf("rsp_ovf%0d", d), o, e.ovf);
            end
            last_id[d]  = id;
            last_sum[d] = s;
            last_ovf[d] = o;
            n_rsp[d]++;
        end else if (v) begin
            hold[d] = 1;
            hid[d]  = id;
            hsum[d] = s;
            hovf[d] = o;
        end else begin
            hold[d] = 0;
        end
    endtask

    always @(negedge clk) begin : monitor
        if (!rst_n) begin
            hold[0] = 0;
            hold[1] = 0;
        end else begin
            mon_one(0, rv0, rid0, rsum0, rovf0);
            mon_one(1, rv1, rid1, rsum1, rovf1);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);   chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_busy0"}, busy0, 0); chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_vld0"}, rv0, 0);    chk({tag, "_vld1"}, rv1, 0);
        chk({tag, "_id0"}, rid0, 0);    chk({tag, "_id1"}, rid1, 0);
        chk({tag, "_sum0"}, rsum0, 0);  chk({tag, "_sum1"}, rsum1, 0);
        chk({tag, "_ovf0"}, rovf0, 0);  chk({tag, "_ovf1"}, rovf1, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic serve(input int i, input logic [3:0] a, input logic [3:0] b);
        bit got = 0;
        @(posedge clk); #1;
        req[i] = 1'b1;
        a_in[4*i +: 4] = a;
        b_in[4*i +: 4] = b;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            got = gnt0[i];
        end
        chk($sformatf("serve_gnt%0d", i), got, 1'b1);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic wait_rsp();
        int  n = n_rsp[0];
        bit  got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = (n_rsp[0] > n);
        end
        chk("rsp_timeout", got, 1'b1);
    endtask

    task automatic wait_vld();
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = rv0;
        end
        chk("vld_timeout", got, 1'b1);
    endtask

    task automatic chk_last(input string tag, input logic [3:0] s0, input logic [3:0] s1,
                            input logic o);
        chk({tag, "_sum_wrap"}, last_sum[0], s0);
        chk({tag, "_sum_sat"}, last_sum[1], s1);
        chk({tag, "_ovf_wrap"}, last_ovf[0], o);
        chk({tag, "_ovf_sat"}, last_ovf[1], o);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] g;
        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b1;
        @(negedge clk);
        chk_zero("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Asynchronous reset while a response is parked.
        rsp_ready = 1'b0;
        serve(2, 4'd3, 4'd2);
        wait_vld();
        chk("t1_pre_sum", rsum0, 4'd5);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req = 4'b0100; a_in[11:8] = 4'd1; b_in[11:8] = 4'd1;
        @(negedge clk);
        chk("t1_gnt", gnt0, 4'b0100);
        @(posedge clk); #1;
        req = '0;
        wait_rsp();
        chk("t1_id", last_id[0], 2'd2);
        chk_last("t1", 4'd2, 4'd2, 1'b0);

        // All four requesting: strict rotation, one grant every 3 cycles.
        do_reset();
        a_in = 16'h1111; b_in = 16'h2222;
        glog_id.delete(); glog_cyc.delete();
        req = 4'hF;
        repeat (14) @(negedge clk);
        @(posedge clk); #1;
        req = '0;
        repeat (6) @(negedge clk);
        chk("t2_ngnt", glog_id.size() >= 5, 1'b1);
        if (glog_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t2_order%0d", k), glog_id[k], k % 4);
                if (k > 0) chk($sformatf("t2_gap%0d", k), glog_cyc[k] - glog_cyc[k-1], 3);
            end
        end
        chk_last("t2", 4'd3, 4'd3, 1'b0);

        // Overflow corners, wrap vs clamp.
        serve(0, 4'd7, 4'd1);  wait_rsp(); chk_last("pos_ovf", 4'b1000, 4'b0111, 1'b1);
        serve(0, 4'h8, 4'hF);  wait_rsp(); chk_last("neg_ovf", 4'b0111, 4'b1000, 1'b1);
        serve(0, 4'hD, 4'h2);  wait_rsp(); chk_last("no_ovf", 4'hF, 4'hF, 1'b0);

        // Backpressure with another requester waiting.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        serve(0, 4'd1, 4'd1);
        wait_vld();
        @(posedge clk); #1;
        req[1] = 1'b1; a_in[7:4] = 4'd5; b_in[7:4] = 4'hE;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t5_gnt%0d", k), gnt0, 4'b0);
            chk($sformatf("t5_busy%0d", k), busy0, 1'b1);
            chk($sformatf("t5_vld%0d", k), rv0, 1'b1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_gnt_after", gnt0, 4'b0010);
        @(posedge clk); #1;
        req[1] = 1'b0;
        wait_rsp();
        chk_last("t5", 4'd3, 4'd3, 1'b0);

        // Pointer sits at 2: 0 wins first, then 1; a short pulse on 3 is ignored.
        @(posedge clk); #1;
        glog_id.delete(); glog_cyc.delete();
        a_in[3:0] = 4'd2; b_in[3:0] = 4'd2; a_in[7:4] = 4'hF; b_in[7:4] = 4'hF;
        req = 4'b0011;
        @(negedge clk);
        chk("t6_gnt_first", gnt0, 4'b0001);
        @(posedge clk); #1;
        req[0] = 1'b0; req[3] = 1'b1;
        @(posedge clk); #1;
        req[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_gnt_second", gnt0, 4'b0010);
        @(posedge clk); #1;
        req[1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_ngnt", glog_id.size(), 2);
        if (glog_id.size() == 2) chk("t6_no_req3", glog_id[1], 1);

        // Randomized traffic: drops, re-requests, random backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = gnt0;
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (req[i] && g[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        a_in[4*i +: 4] = 4'($urandom);
                        b_in[4*i +: 4] = 4'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (req[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    a_in[4*i +: 4] = 4'($urandom);
                    b_in[4*i +: 4] = 4'($urandom);
                end
            end
        end
        @(posedge clk); #1;
        req = '0;
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
